// File: rtl/statevector_pkg.sv
// Shared types and default widths for the statevector memory, controller and readout.
package statevector_pkg;

  localparam int SV_NUM_QUBITS      = 5;
  localparam int SV_AMPLITUDE_WIDTH = 32;
  localparam int SV_NUM_STATES      = 2 ** SV_NUM_QUBITS;
  localparam int SV_ADDR_W          = $clog2(SV_NUM_STATES);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } readout_state_t;

  typedef struct packed {
    logic [SV_ADDR_W-1:0]          index;
    logic [SV_AMPLITUDE_WIDTH-1:0] re;
    logic [SV_AMPLITUDE_WIDTH-1:0] im;
    logic                          last;
  } sv_beat_t;

endpackage

// File: rtl/statevector_readout_if.sv
// Indexed amplitude stream (valid/ready); master drives beats, slave returns ready.
interface statevector_readout_if
  import statevector_pkg::*;
#(
  parameter int ADDR_W          = SV_ADDR_W,
  parameter int AMPLITUDE_WIDTH = SV_AMPLITUDE_WIDTH
) ();

  logic                       out_valid;
  logic                       out_ready;
  logic [ADDR_W-1:0]          out_index;
  logic [AMPLITUDE_WIDTH-1:0] out_re;
  logic [AMPLITUDE_WIDTH-1:0] out_im;
  logic                       out_last;

  modport master (
    output out_valid, out_index, out_re, out_im, out_last,
    input  out_ready
  );

  modport slave (
    input  out_valid, out_index, out_re, out_im, out_last,
    output out_ready
  );

endinterface

// File: rtl/sv_beat_fifo.sv
// Synchronous register FIFO of readout beats; head is read straight from storage, zero read latency.
module sv_beat_fifo
  import statevector_pkg::*;
#(
  parameter type T     = sv_beat_t,
  parameter int  DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  T                 wr_dat_i,
  input  logic             pop_i,
  output T                 rd_dat_o,
  output logic             empty_o,
  output logic             full_o,
  output logic [CNT_W-1:0] count_o
);

  T                 mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [CNT_W-1:0] count_q;

  assign rd_dat_o = mem_q[rd_ptr_q];
  assign empty_o  = (count_q == '0);
  assign full_o   = (count_q == CNT_W'(DEPTH));
  assign count_o  = count_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      // Upstream credit accounting must never let a push land on a full buffer.
      assert (!(push_i && full_o));
      if (push_i) begin
        mem_q[wr_ptr_q] <= wr_dat_i;
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
      if (pop_i) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      count_q <= count_q + CNT_W'(push_i) - CNT_W'(pop_i);
    end
  end

endmodule

// File: rtl/statevector_readout.sv
// Port-B statevector sweeper: first beat 3 cycles after start, credit-limited so out_ready stalls never overflow.
// STATEVECTOR_READOUT_SKIP_ZERO_EN drops all-zero amplitudes except the final element of the range.
module statevector_readout
  import statevector_pkg::*;
#(
  parameter int NUM_QUBITS      = SV_NUM_QUBITS,
  parameter int AMPLITUDE_WIDTH = SV_AMPLITUDE_WIDTH,
  parameter int NUM_STATES      = 2 ** NUM_QUBITS,
  parameter int ADDR_W          = $clog2(NUM_STATES),
  parameter int FIFO_DEPTH      = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic [ADDR_W-1:0]          start_addr,
  input  logic [ADDR_W-1:0]          end_addr,
  output logic                       busy,
  output logic                       done,
  output logic                       mem_portb_en,
  output logic [ADDR_W-1:0]          mem_portb_addr,
  input  logic [AMPLITUDE_WIDTH-1:0] mem_portb_dout_re,
  input  logic [AMPLITUDE_WIDTH-1:0] mem_portb_dout_im,
  statevector_readout_if.master      out_if
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  typedef struct packed {
    logic [ADDR_W-1:0]          index;
    logic [AMPLITUDE_WIDTH-1:0] re;
    logic [AMPLITUDE_WIDTH-1:0] im;
    logic                       last;
  } beat_t;

  readout_state_t    state_q;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W:0]   remaining_q;
  logic              inflight_q;
  logic [ADDR_W-1:0] cap_addr_q;
  logic              cap_last_q;

  logic [ADDR_W-1:0] diff_d;
  logic [ADDR_W:0]   len_d;
  logic [CNT_W-1:0]  fifo_count;
  logic              fifo_empty;
  logic              fifo_full;
  logic              issue;
  logic              final_issue;
  logic              push;
  logic              pop;
  beat_t             wr_beat;
  beat_t             head;

  // Modulo-NUM_STATES span falls out of ADDR_W-bit wraparound; +1 needs the extra bit.
  assign diff_d = end_addr - start_addr;
  assign len_d  = {1'b0, diff_d} + (ADDR_W+1)'(1);

  assign issue       = (state_q == READ) &&
                       ((int'(fifo_count) + int'(inflight_q)) < FIFO_DEPTH);
  assign final_issue = issue && (remaining_q == (ADDR_W+1)'(1));

`ifdef STATEVECTOR_READOUT_SKIP_ZERO_EN
  assign push = inflight_q &&
                (cap_last_q || (mem_portb_dout_re != '0) || (mem_portb_dout_im != '0));
`else
  assign push = inflight_q;
`endif

  assign pop     = !fifo_empty && out_if.out_ready;
  assign wr_beat = '{index: cap_addr_q, re: mem_portb_dout_re,
                     im: mem_portb_dout_im, last: cap_last_q};

  sv_beat_fifo #(
    .T     (beat_t),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push_i   (push),
    .wr_dat_i (wr_beat),
    .pop_i    (pop),
    .rd_dat_o (head),
    .empty_o  (fifo_empty),
    .full_o   (fifo_full),
    .count_o  (fifo_count)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      remaining_q <= '0;
      inflight_q  <= 1'b0;
      cap_addr_q  <= '0;
      cap_last_q  <= 1'b0;
    end else begin
      inflight_q <= issue;
      if (issue) begin
        cap_addr_q  <= addr_q;
        cap_last_q  <= final_issue;
        addr_q      <= addr_q + 1'b1;
        remaining_q <= remaining_q - 1'b1;
      end
      case (state_q)
        IDLE: begin
          if (start) begin
            state_q     <= READ;
            addr_q      <= start_addr;
            remaining_q <= len_d;
          end
        end
        READ: begin
          if (final_issue) state_q <= DRAIN;
        end
        // Leave as soon as this cycle's pop empties the buffer so done lands right after out_last.
        DRAIN: begin
          if (!inflight_q && (fifo_count == CNT_W'(pop))) state_q <= DONE;
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy           = (state_q != IDLE);
  assign done           = (state_q == DONE);
  assign mem_portb_en   = issue;
  assign mem_portb_addr = addr_q;

  assign out_if.out_valid = !fifo_empty;
  assign out_if.out_index = fifo_empty ? '0 : head.index;
  assign out_if.out_re    = fifo_empty ? '0 : head.re;
  assign out_if.out_im    = fifo_empty ? '0 : head.im;
  assign out_if.out_last  = fifo_empty ? 1'b0 : head.last;

endmodule

// File: tb/tb_statevector_readout.sv
// Scoreboarded bench for statevector_readout: full dump, wrap, backpressure, single/busy start, reset mid-sweep.
module tb_statevector_readout;
  import statevector_pkg::*;

  localparam int AW = 5;
  localparam int DW = 32;
  localparam int N  = 32;
`ifdef STATEVECTOR_READOUT_SKIP_ZERO_EN
  localparam bit SKIP = 1'b1;
`else
  localparam bit SKIP = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [AW-1:0] start_addr = '0;
  logic [AW-1:0] end_addr = '0;
  logic          busy, done, mem_portb_en;
  logic [AW-1:0] mem_portb_addr;
  logic [DW-1:0] dout_re = '0;
  logic [DW-1:0] dout_im = '0;
  logic [DW-1:0] mem_re [N];
  logic [DW-1:0] mem_im [N];

  statevector_readout_if #(.ADDR_W(AW), .AMPLITUDE_WIDTH(DW)) out_if ();

  statevector_readout #(.NUM_QUBITS(5), .AMPLITUDE_WIDTH(DW), .FIFO_DEPTH(4)) dut (
    .clk               (clk),
    .rst               (rst),
    .start             (start),
    .start_addr        (start_addr),
    .end_addr          (end_addr),
    .busy              (busy),
    .done              (done),
    .mem_portb_en      (mem_portb_en),
    .mem_portb_addr    (mem_portb_addr),
    .mem_portb_dout_re (dout_re),
    .mem_portb_dout_im (dout_im),
    .out_if            (out_if)
  );

  always #5 clk = ~clk;

  // One-cycle-latency BRAM model on port B
  always @(posedge clk) begin
    if (mem_portb_en) begin
      dout_re <= mem_re[mem_portb_addr];
      dout_im <= mem_im[mem_portb_addr];
    end
  end

  typedef struct packed {
    logic [AW-1:0] idx;
    logic [DW-1:0] re;
    logic [DW-1:0] im;
    logic          last;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  int cyc = 0;
  int start_cyc = 0;
  int en_cnt = 0;
  int pop_cnt = 0;
  int max_out = 0;
  int en_stall = 0;
  int done_cnt = 0;
  int done_cyc = 0;
  int last_pop_cyc = -100;
  bit first_en_seen = 1'b1;
  bit first_vld_seen = 1'b1;
  bit stall_en = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  // Consumer: stalls for relative cycles 5..14 when the backpressure test is active
  initial out_if.out_ready = 1'b1;
  always @(posedge clk) begin
    #1;
    out_if.out_ready = !(stall_en && (cyc - start_cyc) >= 5 && (cyc - start_cyc) <= 14);
  end

  always @(negedge clk) begin
    if (!rst) begin
      if (start && !busy) begin
        start_cyc      = cyc;
        en_cnt         = 0;
        pop_cnt        = 0;
        max_out        = 0;
        en_stall       = 0;
        first_en_seen  = 1'b0;
        first_vld_seen = 1'b0;
      end
      if (en_cnt - pop_cnt > max_out) max_out = en_cnt - pop_cnt;
      if (mem_portb_en) begin
        if (!first_en_seen) begin
          first_en_seen = 1'b1;
          check_eq("first_en_lat", 64'(cyc - start_cyc), 64'd1);
        end
        if (stall_en && (cyc - start_cyc) >= 8 && (cyc - start_cyc) <= 14) en_stall++;
        en_cnt++;
      end
      if (out_if.out_valid && !first_vld_seen) begin
        first_vld_seen = 1'b1;
        check_eq("first_vld_lat", 64'(cyc - start_cyc), 64'd3);
      end
      if (out_if.out_valid && out_if.out_ready) begin
        pop_cnt++;
        if (sb.size() == 0) begin
          check_eq("extra_beat", 64'(out_if.out_index), 64'hFFFF);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check_eq("beat_index", 64'(out_if.out_index), 64'(e.idx));
          check_eq("beat_re", 64'(out_if.out_re), 64'(e.re));
          check_eq("beat_im", 64'(out_if.out_im), 64'(e.im));
          check_eq("beat_last", 64'(out_if.out_last), 64'(e.last));
        end
        if (out_if.out_last) last_pop_cyc = cyc;
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
        check_eq("done_after_last", 64'(cyc - last_pop_cyc), 64'd1);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sweep(input int s, input int e);
    int len;
    len = ((e - s) & (N - 1)) + 1;
    for (int k = 0; k < len; k++) begin
      int a;
      bit lst;
      a   = (s + k) % N;
      lst = (k == len - 1);
      if (!SKIP || lst || mem_re[a] != '0 || mem_im[a] != '0)
        sb.push_back('{idx: AW'(a), re: mem_re[a], im: mem_im[a], last: lst});
    end
    start      = 1'b1;
    start_addr = AW'(s);
    end_addr   = AW'(e);
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int n;
    int d0;
    n  = 0;
    d0 = done_cnt;
    while (done_cnt == d0 && n < 400) begin
      tick();
      n++;
    end
    check_eq(tag, 64'(done_cnt - d0), 64'd1);
    check_eq({tag, "_sb_empty"}, 64'(sb.size()), 64'd0);
    tick();
    check_eq({tag, "_idle"}, 64'(busy), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0;
    int n;
    for (int i = 0; i < N; i++) begin
      mem_re[i] = DW'(i);
      mem_im[i] = ~DW'(i);
    end
    repeat (3) tick();
    check_eq("rst_busy", 64'(busy), 64'd0);
    check_eq("rst_done", 64'(done), 64'd0);
    check_eq("rst_en", 64'(mem_portb_en), 64'd0);
    check_eq("rst_addr", 64'(mem_portb_addr), 64'd0);
    check_eq("rst_valid", 64'(out_if.out_valid), 64'd0);
    check_eq("rst_last", 64'(out_if.out_last), 64'd0);
    rst = 1'b0;
    tick();

    sweep(0, 31);
    wait_done("dump");
    check_eq("dump_en_cnt", 64'(en_cnt), 64'd32);
    check_eq("dump_cycles", 64'(done_cyc - start_cyc), 64'd35);

    sweep(30, 1);
    wait_done("wrap");
    check_eq("wrap_en_cnt", 64'(en_cnt), 64'd4);

    stall_en = 1'b1;
    sweep(0, 31);
    wait_done("bp");
    stall_en = 1'b0;
    check_eq("bp_credit_max", 64'(max_out), 64'd4);
    check_eq("bp_en_stalled", 64'(en_stall), 64'd0);
    check_eq("bp_pops", 64'(pop_cnt), 64'd32);

    sweep(7, 7);
    start      = 1'b1;
    start_addr = '0;
    end_addr   = AW'(31);
    tick();
    start = 1'b0;
    wait_done("single");
    repeat (20) tick();
    check_eq("single_en_cnt", 64'(en_cnt), 64'd1);
    check_eq("single_pops", 64'(pop_cnt), 64'd1);

    sweep(0, 31);
    n = 0;
    while (pop_cnt < 10 && n < 200) begin
      tick();
      n++;
    end
    check_eq("rstmid_reached", 64'(pop_cnt), 64'd10);
    d0  = done_cnt;
    rst = 1'b1;
    tick();
    check_eq("rstmid_valid", 64'(out_if.out_valid), 64'd0);
    check_eq("rstmid_busy", 64'(busy), 64'd0);
    check_eq("rstmid_done", 64'(done), 64'd0);
    rst = 1'b0;
    sb.delete();
    repeat (5) tick();
    check_eq("rstmid_no_done", 64'(done_cnt - d0), 64'd0);
    sweep(0, 3);
    wait_done("post_rst");
    check_eq("post_rst_pops", 64'(pop_cnt), 64'd4);

`ifdef STATEVECTOR_READOUT_SKIP_ZERO_EN
    for (int i = 0; i < N; i++) begin
      mem_re[i] = '0;
      mem_im[i] = '0;
    end
    mem_re[0] = 32'h1234;
    mem_im[5] = 32'h55AA;
    sweep(0, 7);
    wait_done("skip");
    check_eq("skip_pops", 64'(pop_cnt), 64'd3);
    check_eq("skip_en_cnt", 64'(en_cnt), 64'd8);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
